// File: rtl/acc_drain_pkg.sv
// acc_drain_pkg: shared sizes, FSM states and saturation bounds for the ACC drain/requantizer
package acc_drain_pkg;

    localparam int PE_SIZE    = 4;
    localparam int DATA_WIDTH = 32;
    localparam int OUT_WIDTH  = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int ADDR_WIDTH = 8;
    localparam int SHIFT_W    = $clog2(DATA_WIDTH);
    localparam int CNT_W      = $clog2(FIFO_DEPTH);

    // Bounds are held at DATA_WIDTH+1 bits to match the widened rounding datapath
    localparam logic signed [DATA_WIDTH:0] SAT_MAX = (DATA_WIDTH + 1)'(2 ** (OUT_WIDTH - 1) - 1);
    localparam logic signed [DATA_WIDTH:0] SAT_MIN = -SAT_MAX - (DATA_WIDTH + 1)'(1);

    typedef enum logic [1:0] {IDLE, READ, FLUSH, DONE} state_t;

endpackage

// File: rtl/acc_drain_if.sv
// acc_drain_if: ACC read side and GLB write side of the drain controller
//   rden_o      drain -> ACC  per-column FIFO read enable
//   psum_row_i  ACC -> drain  packed psum row, valid one cycle after rden_o
//   glb_wren_o  drain -> GLB  write strobe
//   glb_addr_o  drain -> GLB  write address
//   glb_wdata_o drain -> GLB  packed requantized row
interface acc_drain_if;
    import acc_drain_pkg::*;

    logic [PE_SIZE-1:0]            rden_o;
    logic [DATA_WIDTH*PE_SIZE-1:0] psum_row_i;
    logic                          glb_wren_o;
    logic [ADDR_WIDTH-1:0]         glb_addr_o;
    logic [OUT_WIDTH*PE_SIZE-1:0]  glb_wdata_o;

    modport master (
        output rden_o, glb_wren_o, glb_addr_o, glb_wdata_o,
        input  psum_row_i
    );

    modport slave (
        input  rden_o, glb_wren_o, glb_addr_o, glb_wdata_o,
        output psum_row_i
    );

endinterface

// File: rtl/acc_requant.sv
// acc_requant: single-lane round-half-up shift, optional ReLU and saturation
//   x_i      signed psum
//   shift_i  arithmetic right-shift amount
//   relu_i   clamp negatives to zero
//   y_o      saturated signed result
module acc_requant
    import acc_drain_pkg::*;
(
    input  logic signed [DATA_WIDTH-1:0] x_i,
    input  logic        [SHIFT_W-1:0]    shift_i,
    input  logic                         relu_i,
    output logic signed [OUT_WIDTH-1:0]  y_o
);

    logic signed [DATA_WIDTH:0] rnd;
    logic signed [DATA_WIDTH:0] sh;
    logic signed [DATA_WIDTH:0] cl;

    always_comb begin
        // One extra bit keeps x + 2^(s-1) from overflowing
        rnd = (shift_i == '0) ? '0 : (DATA_WIDTH + 1)'(1) << (shift_i - SHIFT_W'(1));
        sh  = ($signed({x_i[DATA_WIDTH-1], x_i}) + rnd) >>> shift_i;
        cl  = (relu_i && sh[DATA_WIDTH]) ? '0 : sh;
        y_o = (cl > SAT_MAX) ? OUT_WIDTH'(SAT_MAX) :
              (cl < SAT_MIN) ? OUT_WIDTH'(SAT_MIN) : OUT_WIDTH'(cl);
    end

endmodule

// File: rtl/acc_drain.sv
// acc_drain: drains ACC FIFOs on start, requantizes each row and writes it to the GLB
//   clk, rst_n   clock and asynchronous active-low reset
//   start_i      single-cycle drain request, honoured only when idle
//   base_addr_i  GLB address of the first row
//   shift_i      requant right-shift amount
//   relu_en_i    clamp negatives to zero
//   bus          ACC read / GLB write interface (master side)
//   busy_o       high from the cycle after start until done
//   done_o       one-cycle completion pulse
module acc_drain
    import acc_drain_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [SHIFT_W-1:0]    shift_i,
    input  logic                  relu_en_i,
    acc_drain_if.master           bus,
    output logic                  busy_o,
    output logic                  done_o
);

    state_t                       state_q;
    logic [CNT_W-1:0]             cnt_q;
    logic [SHIFT_W-1:0]           shift_q;
    logic                         relu_q;
    logic [ADDR_WIDTH-1:0]        ptr_q;
    logic                         rden_q;
    logic                         vld_q;
    logic                         wren_q;
    logic [ADDR_WIDTH-1:0]        addr_q;
    logic [OUT_WIDTH*PE_SIZE-1:0] wdata_q;
    logic [OUT_WIDTH*PE_SIZE-1:0] wdata_d;
    logic                         busy_q;
    logic                         done_q;

    for (genvar i = 0; i < PE_SIZE; i++) begin : g_lane
        acc_requant u_rq (
            .x_i     (bus.psum_row_i[i*DATA_WIDTH +: DATA_WIDTH]),
            .shift_i (shift_q),
            .relu_i  (relu_q),
            .y_o     (wdata_d[i*OUT_WIDTH +: OUT_WIDTH])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            relu_q  <= 1'b0;
            ptr_q   <= '0;
            rden_q  <= 1'b0;
            vld_q   <= 1'b0;
            wren_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // psum_row_i is valid the cycle after rden; one more stage registers the result
            vld_q  <= rden_q;
            wren_q <= vld_q;
            done_q <= 1'b0;
            if (vld_q) begin
                addr_q  <= ptr_q;
                wdata_q <= wdata_d;
                ptr_q   <= ptr_q + ADDR_WIDTH'(1);
            end
            case (state_q)
                IDLE: if (start_i) begin
                    state_q <= READ;
                    cnt_q   <= '0;
                    shift_q <= shift_i;
                    relu_q  <= relu_en_i;
                    ptr_q   <= base_addr_i;
                    rden_q  <= 1'b1;
                    busy_q  <= 1'b1;
                end
                READ: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(FIFO_DEPTH - 1)) begin
                        state_q <= FLUSH;
                        cnt_q   <= '0;
                        rden_q  <= 1'b0;
                    end
                end
                FLUSH: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.rden_o      = {PE_SIZE{rden_q}};
    assign bus.glb_wren_o  = wren_q;
    assign bus.glb_addr_o  = addr_q;
    assign bus.glb_wdata_o = wdata_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;

endmodule

// File: tb/tb_acc_drain.sv
// tb_acc_drain: directed self-checking bench for acc_drain
module tb_acc_drain;
    import acc_drain_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  start_i = 1'b0;
    logic [ADDR_WIDTH-1:0] base_addr_i = '0;
    logic [SHIFT_W-1:0]    shift_i = '0;
    logic                  relu_en_i = 1'b0;
    logic                  busy_o;
    logic                  done_o;

    always #5 clk = ~clk;

    acc_drain_if bus ();

    acc_drain dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .base_addr_i (base_addr_i),
        .shift_i     (shift_i),
        .relu_en_i   (relu_en_i),
        .bus         (bus),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    int passed = 0;
    int total = 0;

    logic [127:0] rows_m [4];
    logic [3:0]   rden_log [12];
    logic         wren_log [12];
    logic         done_log [12];
    logic         busy_log [12];
    logic [7:0]   addr_log [12];
    logic [31:0]  data_log [12];

    function automatic logic [127:0] pack4(input int a, input int b, input int c, input int d);
        return {d, c, b, a};
    endfunction

    function automatic logic [31:0] pk8(input int a, input int b, input int c, input int d);
        return {d[7:0], c[7:0], b[7:0], a[7:0]};
    endfunction

    task automatic sample(input int k);
        rden_log[k] = bus.rden_o;
        wren_log[k] = bus.glb_wren_o;
        done_log[k] = done_o;
        busy_log[k] = busy_o;
        addr_log[k] = bus.glb_addr_o;
        data_log[k] = bus.glb_wdata_o;
    endtask

    // Starts a drain at cycle 0 and logs cycles 1..11; acts as the ACC FIFO with 1-cycle latency
    task automatic run_drain(input logic [7:0] base, input logic [4:0] sh, input logic rl, input int restart);
        int idx = 0;
        rden_log[0] = '0;
        bus.psum_row_i = '0;
        base_addr_i = base;
        shift_i = sh;
        relu_en_i = rl;
        start_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        base_addr_i = ~base;
        shift_i = ~sh;
        relu_en_i = ~rl;
        for (int k = 1; k < 12; k++) begin
            sample(k);
            if (rden_log[k-1] == 4'hF && idx < 4) begin
                bus.psum_row_i = rows_m[idx];
                idx++;
            end else begin
                bus.psum_row_i = '0;
            end
            start_i = (k == restart);
            @(posedge clk);
            @(negedge clk);
        end
        start_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start_i = 1'b1;
        bus.psum_row_i = '1;
        repeat (3) @(negedge clk);
        total++;
        if ({bus.rden_o, bus.glb_wren_o, bus.glb_addr_o, bus.glb_wdata_o, busy_o, done_o} !== '0)
            $display("FAIL reset_outputs: got rden=%h wren=%b addr=%h data=%h busy=%b done=%b, want all 0",
                     bus.rden_o, bus.glb_wren_o, bus.glb_addr_o, bus.glb_wdata_o, busy_o, done_o);
        else passed++;
        start_i = 1'b0;
        bus.psum_row_i = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            total++;
            if ({bus.rden_o, bus.glb_wren_o, busy_o, done_o} !== 7'd0)
                $display("FAIL reset_idle c%0d: got rden=%h wren=%b busy=%b done=%b, want 0",
                         k, bus.rden_o, bus.glb_wren_o, busy_o, done_o);
            else passed++;
        end
    endtask

    task automatic test_passthrough();
        for (int r = 0; r < 4; r++) rows_m[r] = pack4(r + 4, r + 5, r + 6, r + 7);
        run_drain(8'h10, 5'd0, 1'b0, -1);
        for (int k = 1; k < 12; k++) begin
            total++;
            if ({rden_log[k], wren_log[k], done_log[k], busy_log[k]} !==
                {(k <= 4) ? 4'hF : 4'h0, k >= 3 && k <= 6, k == 7, k <= 7})
                $display("FAIL pass_ctrl c%0d: got rden=%h wren=%b done=%b busy=%b", k,
                         rden_log[k], wren_log[k], done_log[k], busy_log[k]);
            else passed++;
        end
        for (int k = 3; k <= 6; k++) begin
            total++;
            if (addr_log[k] !== 8'(8'h10 + k - 3) || data_log[k] !== pk8(k + 1, k + 2, k + 3, k + 4))
                $display("FAIL pass_row c%0d: got addr=%h data=%h want addr=%h data=%h", k,
                         addr_log[k], data_log[k], 8'(8'h10 + k - 3), pk8(k + 1, k + 2, k + 3, k + 4));
            else passed++;
        end
        total++;
        if (addr_log[9] !== 8'h13 || data_log[9] !== pk8(7, 8, 9, 10))
            $display("FAIL pass_hold: got addr=%h data=%h want 13 %h", addr_log[9], data_log[9], pk8(7, 8, 9, 10));
        else passed++;
    endtask

    task automatic test_rounding();
        for (int r = 0; r < 4; r++) rows_m[r] = pack4(24, 23, -24, -25);
        run_drain(8'h00, 5'd4, 1'b0, -1);
        for (int k = 3; k <= 6; k++) begin
            total++;
            if (data_log[k] !== pk8(2, 1, -1, -2))
                $display("FAIL round_s4 c%0d: got %h want %h", k, data_log[k], pk8(2, 1, -1, -2));
            else passed++;
        end
        for (int r = 0; r < 4; r++) rows_m[r] = pack4(3, -3, 1, -1);
        run_drain(8'h00, 5'd1, 1'b0, -1);
        total++;
        if (data_log[3] !== pk8(2, -1, 1, 0))
            $display("FAIL round_s1: got %h want %h", data_log[3], pk8(2, -1, 1, 0));
        else passed++;
    endtask

    task automatic test_saturation();
        for (int r = 0; r < 4; r++) rows_m[r] = pack4(1000, -1000, -5, 127);
        run_drain(8'h40, 5'd0, 1'b0, -1);
        total++;
        if (data_log[3] !== pk8(127, -128, -5, 127))
            $display("FAIL sat_norelu: got %h want %h", data_log[3], pk8(127, -128, -5, 127));
        else passed++;
        run_drain(8'h40, 5'd0, 1'b1, -1);
        for (int k = 3; k <= 6; k++) begin
            total++;
            if (data_log[k] !== pk8(127, 0, 0, 127))
                $display("FAIL sat_relu c%0d: got %h want %h", k, data_log[k], pk8(127, 0, 0, 127));
            else passed++;
        end
    endtask

    task automatic test_wrap_busy();
        logic [7:0] exp_a [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        int writes = 0;
        int dones = 0;
        int busys = 0;
        for (int r = 0; r < 4; r++) rows_m[r] = pack4(r, 0, 0, 0);
        run_drain(8'hFE, 5'd0, 1'b0, 2);
        for (int k = 1; k < 12; k++) begin
            writes += int'(wren_log[k]);
            dones += int'(done_log[k]);
            busys += int'(busy_log[k]);
        end
        for (int k = 3; k <= 6; k++) begin
            total++;
            if (addr_log[k] !== exp_a[k-3] || data_log[k] !== pk8(k - 3, 0, 0, 0))
                $display("FAIL wrap_addr c%0d: got addr=%h data=%h want addr=%h", k, addr_log[k], data_log[k], exp_a[k-3]);
            else passed++;
        end
        total++;
        if (writes !== 4 || dones !== 1 || busys !== 7)
            $display("FAIL wrap_counts: got writes=%0d dones=%0d busy=%0d want 4 1 7", writes, dones, busys);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int writes = 0;
        for (int r = 0; r < 4; r++) rows_m[r] = pack4(r + 4, r + 5, r + 6, r + 7);
        base_addr_i = 8'h20;
        start_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.psum_row_i = rows_m[0];
        @(posedge clk);
        @(negedge clk);
        bus.psum_row_i = rows_m[1];
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus.rden_o, bus.glb_wren_o, bus.glb_addr_o, bus.glb_wdata_o, busy_o, done_o} !== '0)
            $display("FAIL midreset_outputs: got rden=%h wren=%b addr=%h data=%h busy=%b done=%b, want all 0",
                     bus.rden_o, bus.glb_wren_o, bus.glb_addr_o, bus.glb_wdata_o, busy_o, done_o);
        else passed++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bus.psum_row_i = '0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            writes += int'(bus.glb_wren_o);
        end
        total++;
        if (writes !== 0 || busy_o !== 1'b0)
            $display("FAIL midreset_quiet: got writes=%0d busy=%b want 0 0", writes, busy_o);
        else passed++;
        run_drain(8'h30, 5'd0, 1'b0, -1);
        for (int k = 1; k < 12; k++) begin
            total++;
            if ({rden_log[k], wren_log[k], done_log[k], busy_log[k]} !==
                {(k <= 4) ? 4'hF : 4'h0, k >= 3 && k <= 6, k == 7, k <= 7})
                $display("FAIL after_ctrl c%0d: got rden=%h wren=%b done=%b busy=%b", k,
                         rden_log[k], wren_log[k], done_log[k], busy_log[k]);
            else passed++;
        end
        total++;
        if (addr_log[3] !== 8'h30 || data_log[6] !== pk8(7, 8, 9, 10))
            $display("FAIL after_row: got addr=%h data=%h want 30 %h", addr_log[3], data_log[6], pk8(7, 8, 9, 10));
        else passed++;
    endtask

    initial begin
        bus.psum_row_i = '0;
        test_reset();
        test_passthrough();
        test_rounding();
        test_saturation();
        test_wrap_busy();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
